exposure_timer: RTL and testbench
=================================

Name: exposure_timer

Overview:
Upstream companion of the camera exposure/readout controller. It holds the user-adjustable exposure time, which the Exp_increase/Exp_decrease buttons step up and down. It starts a countdown when the controller raises Start. When the programmed exposure time has elapsed, it emits the one-cycle Ovf5 pulse that ends exposure and triggers pixel readout.

Parameters:
EXP_MIN, 2, lowest exposure setting in time units (must be >= 1)
EXP_MAX, 30, highest exposure setting in time units (must be <= 2**EXP_W-1)
EXP_DEFAULT, 15, setting loaded at reset (EXP_MIN <= EXP_DEFAULT <= EXP_MAX)
EXP_W, 5, width of exposure setting and unit counter
TICKS_PER_UNIT, 4, Clk cycles per exposure time unit (prescaler modulus, >= 1)

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  from exposure controller; rising edge starts countdown
Exp_increase  input  1  button level; rising edge steps setting +1
Exp_decrease  input  1  button level; rising edge steps setting -1
Ovf5  output  1  registered one-cycle pulse: exposure time elapsed
Busy  output  1  high while counting or waiting for Start to fall
Exp_time  output  EXP_W  current exposure setting in time units

Behaviour:
- Reset (synchronous, active-high) sets Exp_time=EXP_DEFAULT, Ovf5=0, Busy=0, state=IDLE, prescaler=0, unit counter=0, and clears all edge-detect history registers to 0.
- Edge detection: each of Start, Exp_increase and Exp_decrease is registered once. A rising edge is (current sample & ~previous sample).
- States:
  - IDLE: Busy=0.
    - Start rising edge at clock edge k: load unit counter=Exp_time, prescaler=0, go to COUNT.
    - Increase rising edge only: Exp_time += 1, saturating at EXP_MAX.
    - Decrease rising edge only: Exp_time -= 1, saturating at EXP_MIN.
    - Increase and decrease rising edges in the same cycle: no change.
  - COUNT: Busy=1.
    - Prescaler counts 0..TICKS_PER_UNIT-1 and wraps to 0.
    - The unit counter decrements on each wrap.
    - When the unit counter reaches 0 on a wrap: Ovf5=1 for exactly one cycle, go to DONE.
    - Timing: Ovf5 is registered high after edge k + Exp_time*TICKS_PER_UNIT and low again after the next edge.
    - Start sampled 0 while in COUNT: abort, go to IDLE, no Ovf5.
  - DONE: Busy=1. Waits for Start sampled 0, then goes to IDLE. Start staying high never retriggers a count.
- Button edges while Busy=1 are discarded, not queued. Exp_time is frozen for the whole exposure.
- Ovf5 is never high for more than one cycle and never high in IDLE.
- Reset has priority over every other event, including a pending Ovf5 and a mid-count state; the countdown is lost.
- Start rising in the same cycle as a button edge: the count starts and the button edge is discarded.
- Exp_time = EXP_MIN with TICKS_PER_UNIT = 1 is a legal minimal count of EXP_MIN cycles.
- No arithmetic wraps: all increments and decrements are saturating or bounded by state.

Decomposition:
- Package exposure_pkg:
  - EXP_W, EXP_MIN, EXP_MAX, EXP_DEFAULT constants.
  - State enum (IDLE, COUNT, DONE, 2-bit encoding).
  - Elaboration-time parameter range checks.
- Sub-module rise_detect: 1-bit register plus AND, one rising-edge pulse output. Instantiated three times (Start, Exp_increase, Exp_decrease).
- Prescaler, unit counter and FSM stay in exposure_timer.

Test Plan:
1. Reset, then idle 10 cycles -> Exp_time=15, Ovf5=0, Busy=0 throughout.
2. Start rises and stays high (defaults) -> Busy=1 next cycle; Ovf5 exactly 1 cycle high after 60 cycles; Busy stays 1 until Start falls, then 0; no second Ovf5.
3. Five Exp_increase pulses from 28, then Exp_decrease pulses from 3 down to 1 -> Exp_time saturates at 30, then at 2; both buttons rising together -> unchanged.
4. Set Exp_time=2, Start rises, press Exp_increase during the count -> Ovf5 after 8 cycles; Exp_time still 2 afterwards.
5. Start rises, drops after 20 cycles -> no Ovf5, Busy=0 next cycle; a new Start rise gives a full 60-cycle count.
6. Reset asserted 30 cycles into a count with Exp_time=20 -> next cycle Busy=0, Exp_time=15, Ovf5 never pulses.

Source files
------------

// File: rtl/exposure_pkg.sv
// Shared constants, state encoding and configuration checks for the exposure timer.
package exposure_pkg;

  localparam int unsigned EXP_W       = 5;
  localparam int unsigned EXP_MIN     = 2;
  localparam int unsigned EXP_MAX     = 30;
  localparam int unsigned EXP_DEFAULT = 15;

  localparam bit EXP_CFG_OK = (EXP_MIN >= 1) &&
                              (EXP_MAX <= (2 ** EXP_W) - 1) &&
                              (EXP_MIN <= EXP_DEFAULT) &&
                              (EXP_DEFAULT <= EXP_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/exposure_timer_rise_detect.sv
// Single-bit rising-edge detector: one history register plus an AND.
module rise_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic Sig,
  output logic Rise
);

  logic prev;

  always_ff @(posedge Clk) begin
    if (Reset) prev <= 1'b0;
    else       prev <= Sig;
  end

  assign Rise = Sig & ~prev;

endmodule

// File: rtl/exposure_timer.sv
// Exposure setting holder and countdown timer; emits a one-cycle Ovf5 pulse
// when the programmed exposure time has elapsed after a Start rising edge.
module exposure_timer
  import exposure_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  output logic             Ovf5,
  output logic             Busy,
  output logic [EXP_W-1:0] Exp_time
);

  localparam int unsigned   PW       = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_UNIT - 1);
  localparam logic [EXP_W-1:0] E_MIN = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] E_MAX = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] E_DEF = EXP_W'(EXP_DEFAULT);
  localparam logic [EXP_W-1:0] E_ONE = EXP_W'(1);

  if (!EXP_CFG_OK || (TICKS_PER_UNIT < 1)) begin : g_bad_cfg
    $error("exposure_timer: illegal parameter configuration");
  end

  logic start_rise;
  logic inc_rise;
  logic dec_rise;

  rise_detect u_start_rd (.Clk(Clk), .Reset(Reset), .Sig(Start),        .Rise(start_rise));
  rise_detect u_inc_rd   (.Clk(Clk), .Reset(Reset), .Sig(Exp_increase), .Rise(inc_rise));
  rise_detect u_dec_rd   (.Clk(Clk), .Reset(Reset), .Sig(Exp_decrease), .Rise(dec_rise));

  state_e             state;
  logic [PW-1:0]      prescale;
  logic [EXP_W-1:0]   unit_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      Exp_time <= E_DEF;
      Ovf5     <= 1'b0;
      Busy     <= 1'b0;
      prescale <= '0;
      unit_cnt <= '0;
    end else begin
      Ovf5 <= 1'b0;
      unique case (state)
        IDLE: begin
          // Start wins over a simultaneous button edge; the button edge is dropped.
          if (start_rise) begin
            unit_cnt <= Exp_time;
            prescale <= '0;
            state    <= COUNT;
            Busy     <= 1'b1;
          end else if (inc_rise && !dec_rise && (Exp_time != E_MAX)) begin
            Exp_time <= Exp_time + 1'b1;
          end else if (dec_rise && !inc_rise && (Exp_time != E_MIN)) begin
            Exp_time <= Exp_time - 1'b1;
          end
        end
        COUNT: begin
          if (!Start) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else if (prescale == PRE_LAST) begin
            prescale <= '0;
            unit_cnt <= unit_cnt - 1'b1;
            if (unit_cnt == E_ONE) begin
              Ovf5  <= 1'b1;
              state <= DONE;
            end
          end else begin
            prescale <= prescale + 1'b1;
          end
        end
        DONE: begin
          if (!Start) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exposure_timer.sv
// Scoreboard bench for exposure_timer: stimulus pushes expected Ovf5 events,
// a negedge monitor pops and compares them.
module tb_exposure_timer;

  localparam int T       = 4;
  localparam int E_MIN   = 2;
  localparam int E_MAX   = 30;
  localparam int E_DEF   = 15;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Exp_increase = 1'b0;
  logic       Exp_decrease = 1'b0;
  logic       Ovf5;
  logic       Busy;
  logic [4:0] Exp_time;

  exposure_timer #(.TICKS_PER_UNIT(T)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Exp_increase(Exp_increase), .Exp_decrease(Exp_decrease),
    .Ovf5(Ovf5), .Busy(Busy), .Exp_time(Exp_time)
  );

  always #5 Clk = ~Clk;

  typedef struct { int cyc; int exp; } ovf_t;
  ovf_t sb[$];

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  m_exp = E_DEF;
  bit  m_busy = 0;
  bit  prev_ovf = 0;

  always @(posedge Clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Ovf5 pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && Ovf5) begin
      check("ovf_single_cycle", prev_ovf, 0);
      check("ovf_busy", Busy, 1);
      if (sb.size() == 0) begin
        check("ovf_unexpected", 1, 0);
      end else begin
        ovf_t e;
        e = sb.pop_front();
        check("ovf_cycle", cyc, e.cyc);
        check("ovf_exp_frozen", Exp_time, e.exp);
      end
    end
    prev_ovf = Ovf5;
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic int clamp_step(input int e, input bit inc, input bit dec);
    if (inc && !dec) return (e + 1 > E_MAX) ? E_MAX : e + 1;
    if (dec && !inc) return (e - 1 < E_MIN) ? E_MIN : e - 1;
    return e;
  endfunction

  task automatic press(input bit inc, input bit dec);
    Exp_increase = inc;
    Exp_decrease = dec;
    step(1);
    Exp_increase = 0;
    Exp_decrease = 0;
    step(1);
    if (!m_busy) m_exp = clamp_step(m_exp, inc, dec);
    check("exp_time", Exp_time, m_exp);
  endtask

  task automatic set_exp(input int target);
    while (m_exp != target) press(target > m_exp, target < m_exp);
  endtask

  // Start rises; optional simultaneous button edge that must be ignored.
  task automatic start_count(input bit inc, input bit dec);
    ovf_t e;
    e.cyc = cyc + 1 + m_exp * T;
    e.exp = m_exp;
    sb.push_back(e);
    Start = 1;
    Exp_increase = inc;
    Exp_decrease = dec;
    step(1);
    Exp_increase = 0;
    Exp_decrease = 0;
    m_busy = 1;
    check("busy_after_start", Busy, 1);
  endtask

  task automatic wait_done(input int hold);
    int rem;
    rem = (sb.size() > 0) ? sb[$].cyc - cyc : 0;
    if (rem > 0) step(rem);
    step(1);
    check("ovf_timeout", sb.size(), 0);
    check("ovf_low_after", Ovf5, 0);
    if (hold > 0) step(hold);
    check("busy_done_hold", Busy, 1);
    Start = 0;
    step(1);
    m_busy = 0;
    check("busy_after_release", Busy, 0);
    check("exp_after_count", Exp_time, m_exp);
  endtask

  task automatic abort_after(input int d);
    if (d > 0) step(d);
    Start = 0;
    step(1);
    m_busy = 0;
    void'(sb.pop_back());
    check("busy_after_abort", Busy, 0);
  endtask

  initial begin
    int n;
    // 1: reset and idle
    Reset = 1;
    step(2);
    Reset = 0;
    check("rst_ovf", Ovf5, 0);
    for (int i = 0; i < 10; i++) begin
      check("idle_exp", Exp_time, E_DEF);
      check("idle_busy", Busy, 0);
      step(1);
    end

    // 2: full count with Start held high, no retrigger
    start_count(0, 0);
    wait_done(10);

    // 3: saturation and simultaneous buttons
    set_exp(28);
    for (int i = 0; i < 5; i++) press(1, 0);
    check("sat_max", Exp_time, E_MAX);
    set_exp(3);
    for (int i = 0; i < 3; i++) press(0, 1);
    check("sat_min", Exp_time, E_MIN);
    press(1, 1);
    set_exp(10);
    press(1, 1);

    // 4: minimum setting, button during count ignored
    set_exp(2);
    start_count(0, 0);
    press(1, 0);
    wait_done(0);
    check("exp_frozen", Exp_time, 2);

    // 5: abort then full count
    set_exp(E_DEF);
    start_count(0, 0);
    abort_after(19);
    start_count(0, 0);
    wait_done(2);

    // 6: reset mid-count
    set_exp(20);
    start_count(0, 0);
    step(30);
    Reset = 1;
    Start = 0;
    step(1);
    Reset = 0;
    sb.delete();
    m_busy = 0;
    m_exp = E_DEF;
    check("rst_mid_busy", Busy, 0);
    check("rst_mid_exp", Exp_time, E_DEF);
    check("rst_mid_ovf", Ovf5, 0);
    step(90);
    check("rst_mid_busy_later", Busy, 0);

    // Randomized transactions
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 4);
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 3))
          0: press(1, 0);
          1: press(0, 1);
          2: press(1, 1);
          default: press(1, 0);
        endcase
      end
      case ($urandom_range(0, 2))
        0: start_count(0, 0);
        1: start_count(1, 0);
        default: start_count(0, 1);
      endcase
      case ($urandom_range(0, 2))
        0: wait_done($urandom_range(0, 5));
        1: abort_after($urandom_range(0, m_exp * T - 2));
        default: begin
          press($urandom_range(0, 1), $urandom_range(0, 1));
          wait_done($urandom_range(0, 3));
        end
      endcase
      step($urandom_range(0, 2));
    end

    step(5);
    check("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule
